muldiv_sequencer: RTL and testbench

Multi-cycle sequencer for the shared multiplier/divider datapath of the multicycle CPU. The main control FSM issues a one-cycle start request for MULT or DIV. This block then performs three steps: it loads the operands into the selected unit, steps that unit for a fixed iteration count, and writes HI/LO. It reports completion with a `done` pulse, or reports a zero divisor with a `divzero` pulse. It owns the `mloadab`, `mult`, `dloadab`, `div`, `muxhigh`, `muxlow`, `highwrite` and `lowwrite` strobes, which the main FSM no longer drives directly.

---
 rtl/muldiv_sequencer.sv | 118 +++++++++++
 tb/tb_muldiv_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer
// Brief    : Load/step/write sequencer for the shared multiplier/divider.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
  parameter int ITERS = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start_mult,
  input  logic start_div,
  input  logic divisor_zero,
  output logic mloadab,
  output logic mult,
  output logic dloadab,
  output logic div,
  output logic muxhigh,
  output logic muxlow,
  output logic highwrite,
  output logic lowwrite,
  output logic busy,
  output logic done,
  output logic divzero
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CALC  = 3'd2,
    WRITE = 3'd3,
    DZERO = 3'd4
  } state_t;

  localparam logic [5:0] C_LAST = 6'(ITERS - 1);

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       is_div_q, is_div_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      is_div_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    mloadab   = 1'b0;
    mult      = 1'b0;
    dloadab   = 1'b0;
    div       = 1'b0;
    muxhigh   = 1'b0;
    muxlow    = 1'b0;
    highwrite = 1'b0;
    lowwrite  = 1'b0;
    done      = 1'b0;
    divzero   = 1'b0;
    busy      = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        // Multiply has priority; a simultaneous divide request is dropped.
        if (start_mult) begin
          state_d  = LOAD;
          is_div_d = 1'b0;
        end else if (start_div) begin
          if (divisor_zero) begin
            state_d = DZERO;
          end else begin
            state_d  = LOAD;
            is_div_d = 1'b1;
          end
        end
      end
      LOAD: begin
        mloadab = ~is_div_q;
        dloadab = is_div_q;
        cnt_d   = 6'd0;
        state_d = CALC;
      end
      CALC: begin
        mult  = ~is_div_q;
        div   = is_div_q;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == C_LAST) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        highwrite = 1'b1;
        lowwrite  = 1'b1;
        muxhigh   = is_div_q;
        muxlow    = is_div_q;
        done      = 1'b1;
        state_d   = IDLE;
      end
      DZERO: begin
        divzero = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_sequencer
// Brief    : Self-checking bench for muldiv_sequencer (ITERS=32 and ITERS=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_mult = 1'b0;
  logic start_div = 1'b0;
  logic divisor_zero = 1'b0;

  // Output bit order: mloadab mult dloadab div muxhigh muxlow highwrite lowwrite busy done divzero
  logic [10:0] ov [2];

  muldiv_sequencer #(.ITERS(32)) u_dut32 (
    .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .divisor_zero(divisor_zero),
    .mloadab(ov[0][10]), .mult(ov[0][9]), .dloadab(ov[0][8]), .div(ov[0][7]),
    .muxhigh(ov[0][6]), .muxlow(ov[0][5]), .highwrite(ov[0][4]), .lowwrite(ov[0][3]),
    .busy(ov[0][2]), .done(ov[0][1]), .divzero(ov[0][0])
  );

  muldiv_sequencer #(.ITERS(1)) u_dut1 (
    .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .divisor_zero(divisor_zero),
    .mloadab(ov[1][10]), .mult(ov[1][9]), .dloadab(ov[1][8]), .div(ov[1][7]),
    .muxhigh(ov[1][6]), .muxlow(ov[1][5]), .highwrite(ov[1][4]), .lowwrite(ov[1][3]),
    .busy(ov[1][2]), .done(ov[1][1]), .divzero(ov[1][0])
  );

  always #5 clk = ~clk;

  localparam logic [10:0] B_MLOAD = 11'b100_0000_0000;
  localparam logic [10:0] B_MULT  = 11'b010_0000_0000;
  localparam logic [10:0] B_DLOAD = 11'b001_0000_0000;
  localparam logic [10:0] B_DIV   = 11'b000_1000_0000;
  localparam logic [10:0] B_MUXH  = 11'b000_0100_0000;
  localparam logic [10:0] B_MUXL  = 11'b000_0010_0000;
  localparam logic [10:0] B_HW    = 11'b000_0001_0000;
  localparam logic [10:0] B_LW    = 11'b000_0000_1000;
  localparam logic [10:0] B_BUSY  = 11'b000_0000_0100;
  localparam logic [10:0] B_DONE  = 11'b000_0000_0010;
  localparam logic [10:0] B_DZ    = 11'b000_0000_0001;

  int total = 0;
  int bad   = 0;

  // Reference model: each unit is described by the number of cycles since
  // its request was accepted (0 = idle), the operation kind and whether it
  // was a divide-by-zero.
  int ph [2] = '{0, 0};
  bit md [2] = '{1'b0, 1'b0};
  bit mz [2] = '{1'b0, 1'b0};
  int itn [2] = '{32, 1};

  function automatic logic [10:0] expect_out(int p, bit d, bit z, int n);
    logic [10:0] v;
    v = '0;
    if (p == 0) return v;
    v = v | B_BUSY;
    if (z) v = v | B_DZ;
    else if (p == 1) v = v | (d ? B_DLOAD : B_MLOAD);
    else if (p <= n + 1) v = v | (d ? B_DIV : B_MULT);
    else v = v | B_HW | B_LW | B_DONE | (d ? (B_MUXH | B_MUXL) : 11'b0);
    return v;
  endfunction

  task automatic check(string name, int act, int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Observation counters for the ITERS=32 unit, relative to cycle `cyc`.
  int cyc, n_mload, n_mult, n_dload, n_div, n_done, n_hw, n_dz;
  int done_at, mload_at, dload_at, dz_at, last_busy;
  logic [1:0] mux_at_done;

  task automatic clr_counts();
    cyc = 0; n_mload = 0; n_mult = 0; n_dload = 0; n_div = 0; n_done = 0;
    n_hw = 0; n_dz = 0; done_at = -1; mload_at = -1; dload_at = -1;
    dz_at = -1; last_busy = -1; mux_at_done = 2'b00;
  endtask

  task automatic step(bit sm, bit sd, bit dz, bit rst);
    @(negedge clk);
    start_mult = sm; start_div = sd; divisor_zero = dz; reset = rst;
    @(posedge clk);
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        ph[u] = 0; md[u] = 1'b0; mz[u] = 1'b0;
      end else if (ph[u] == 0) begin
        if (sm) begin ph[u] = 1; md[u] = 1'b0; mz[u] = 1'b0; end
        else if (sd) begin ph[u] = 1; md[u] = 1'b1; mz[u] = dz; end
      end else if (mz[u] || ph[u] == itn[u] + 2) begin
        ph[u] = 0;
      end else begin
        ph[u]++;
      end
    end
    #1;
    cyc++;
    for (int u = 0; u < 2; u++) begin
      logic [10:0] e;
      e = expect_out(ph[u], md[u], mz[u], itn[u]);
      total++;
      if (ov[u] !== e) begin
        bad++;
        $display("FAIL model_iters%0d cyc%0d: got %b, required %b", itn[u], cyc, ov[u], e);
      end
    end
    if (ov[0][10]) begin n_mload++; mload_at = cyc; end
    if (ov[0][9])  n_mult++;
    if (ov[0][8])  begin n_dload++; dload_at = cyc; end
    if (ov[0][7])  n_div++;
    if (ov[0][4] || ov[0][3]) n_hw++;
    if (ov[0][2])  last_busy = cyc;
    if (ov[0][1])  begin n_done++; done_at = cyc; mux_at_done = ov[0][6:5]; end
    if (ov[0][0])  begin n_dz++; dz_at = cyc; end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    bit          sm;
    bit          sd;
    bit          dz;
    logic [10:0] exp32;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 11'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, B_MLOAD | B_BUSY};
    vecs[2] = '{1'b0, 1'b1, 1'b0, B_DLOAD | B_BUSY};
    vecs[3] = '{1'b0, 1'b1, 1'b1, B_DZ | B_BUSY};
    vecs[4] = '{1'b1, 1'b1, 1'b0, B_MLOAD | B_BUSY};
    vecs[5] = '{1'b1, 1'b1, 1'b1, B_MLOAD | B_BUSY};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 11'b0};

    // Reset held two cycles, then quiet
    clr_counts();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_outputs_zero", int'(ov[0]), 0);
    idle(10);
    check("idle_no_busy", last_busy, -1);

    // First-cycle response to each request pattern from IDLE
    for (int i = 0; i < 7; i++) begin
      step(vecs[i].sm, vecs[i].sd, vecs[i].dz, 1'b0);
      check($sformatf("vec%0d_first_cycle", i), int'(ov[0]), int'(vecs[i].exp32));
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check($sformatf("vec%0d_after_reset", i), int'(ov[0]), 0);
    end

    // Multiply
    clr_counts();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(40);
    check("mul_mload_at", mload_at, 1);
    check("mul_mult_cycles", n_mult, 32);
    check("mul_done_at", done_at, 34);
    check("mul_done_count", n_done, 1);
    check("mul_mux_at_done", int'(mux_at_done), 0);
    check("mul_last_busy", last_busy, 34);

    // Divide
    clr_counts();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(40);
    check("div_dload_at", dload_at, 1);
    check("div_div_cycles", n_div, 32);
    check("div_done_at", done_at, 34);
    check("div_mux_at_done", int'(mux_at_done), 3);

    // Divide by zero
    clr_counts();
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(10);
    check("dz_at", dz_at, 1);
    check("dz_count", n_dz, 1);
    check("dz_no_done", n_done + n_hw + n_div, 0);
    check("dz_last_busy", last_busy, 1);

    // Simultaneous requests run a multiply
    clr_counts();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(40);
    check("both_mult_cycles", n_mult, 32);
    check("both_no_div", n_div + n_dload, 0);

    // Divide request at cycle 10 of a multiply is ignored
    clr_counts();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(8);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(40);
    check("coll_done_count", n_done, 1);
    check("coll_done_at", done_at, 34);
    check("coll_no_div", n_div + n_dload, 0);

    // Start during WRITE ignored; start in first IDLE cycle accepted
    clr_counts();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(33);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("write_start_ignored", int'(ov[0]), 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("b2b_load", int'(ov[0]), int'(B_MLOAD | B_BUSY));
    idle(40);
    check("b2b_mload_count", n_mload, 2);
    check("b2b_done_at", done_at, 36 + 33);

    // Reset in the middle of a divide
    clr_counts();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(19);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("midreset_outputs", int'(ov[0]), 0);
    idle(40);
    check("midreset_no_write", n_done + n_hw, 0);
    clr_counts();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(40);
    check("post_reset_done_at", done_at, 34);

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
           1'(($urandom & 32'h1)), ($urandom_range(0, 199) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
